mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between two requesters: the CPU instruction-fetch port (read-only) and the CPU data port (read/write).
- Sits between the cpu core and the memory model/SRAM wrapper.
- One transaction is outstanding at a time. Responses are registered and routed back to the granted requester.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arb_select.sv | 29 ++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: memory address/data types,
// FSM state encoding and grant encoding.
package mem_arbiter_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 8;
  localparam int unsigned MEM_DATA_WIDTH = 8;

  typedef logic [MEM_ADDR_WIDTH-1:0] memory_address_t;
  typedef logic [MEM_DATA_WIDTH-1:0] memory_data_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD_WAIT,
    RESP
  } mem_arb_state_t;

  typedef enum logic {
    GRANT_FETCH,
    GRANT_DATA
  } mem_arb_grant_t;

endpackage

// File: rtl/mem_arb_select.sv
// Two-way combinational arbiter between instruction fetch and data port.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin on ties,
// otherwise fixed priority data over fetch).
module mem_arb_select
  import mem_arbiter_pkg::*;
(
  input  logic           if_req,
  input  logic           dm_req,
  input  mem_arb_grant_t last,
  output mem_arb_grant_t grant
);

  // Pick the winner; with no request the result simply echoes the pointer.
  always_comb begin
    grant = last;
    if (if_req && dm_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant = (last == GRANT_DATA) ? GRANT_FETCH : GRANT_DATA;
`else
      grant = GRANT_DATA;
`endif
    end else if (dm_req) begin
      grant = GRANT_DATA;
    end else if (if_req) begin
      grant = GRANT_FETCH;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the CPU fetch port (read-only)
// and the CPU data port (read/write); one transaction in flight at a time.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin arbitration
// with a 1-bit last-grant pointer).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_if_rsp_data,
  input  logic                  i_dm_req,
  input  logic                  i_dm_we,
  input  logic [ADDR_WIDTH-1:0] i_dm_addr,
  input  logic [DATA_WIDTH-1:0] i_dm_wr_data,
  output logic                  o_dm_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_dm_rsp_data,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wr_data,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data
);

  mem_arb_state_t state;
  mem_arb_grant_t grant;
  mem_arb_grant_t last;
  mem_arb_grant_t pick;
  logic           any_req;
  logic           rd_capture;
  logic           finish;

  assign any_req = i_if_req | i_dm_req;

`ifndef MEM_ARB_ROUND_ROBIN_EN
  assign last = GRANT_FETCH;
`endif

  mem_arb_select u_select (
    .if_req (i_if_req),
    .dm_req (i_dm_req),
    .last   (last),
    .grant  (pick)
  );

  // Completion conditions: read data captured, or write accepted downstream.
  // o_mem_we is the registered transaction direction.
  always_comb begin
    rd_capture = 1'b0;
    finish     = 1'b0;
    if (state == ISSUE && i_mem_ready) begin
      rd_capture = !o_mem_we && i_mem_rd_valid;
      finish     = o_mem_we || i_mem_rd_valid;
    end else if (state == RD_WAIT && i_mem_rd_valid) begin
      rd_capture = 1'b1;
      finish     = 1'b1;
    end
  end

  // Transaction FSM with registered downstream request and response outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= IDLE;
      grant          <= GRANT_FETCH;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last           <= GRANT_FETCH;
`endif
      o_mem_req      <= 1'b0;
      o_mem_we       <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_wr_data  <= '0;
      o_if_rsp_valid <= 1'b0;
      o_if_rsp_data  <= '0;
      o_dm_rsp_valid <= 1'b0;
      o_dm_rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= pick;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last      <= pick;
`endif
            o_mem_req <= 1'b1;
            if (pick == GRANT_DATA) begin
              o_mem_we      <= i_dm_we;
              o_mem_addr    <= i_dm_addr;
              o_mem_wr_data <= i_dm_wr_data;
            end else begin
              o_mem_we      <= 1'b0;
              o_mem_addr    <= i_if_addr;
              o_mem_wr_data <= '0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_mem_ready) begin
            o_mem_req <= 1'b0;
            state     <= finish ? RESP : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (i_mem_rd_valid) begin
            state <= RESP;
          end
        end
        RESP: begin
          o_if_rsp_valid <= 1'b0;
          o_dm_rsp_valid <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Response pulse and data capture, routed to the granted requester.
      if (finish) begin
        if (grant == GRANT_DATA) begin
          o_dm_rsp_valid <= 1'b1;
          if (rd_capture) o_dm_rsp_data <= i_mem_rd_data;
        end else begin
          o_if_rsp_valid <= 1'b1;
          if (rd_capture) o_if_rsp_data <= i_mem_rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard testbench for mem_arbiter with a behavioural memory
// responder. Honours MEM_ARB_ROUND_ROBIN_EN when predicting tie order.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_req;
  logic [7:0] if_addr;
  logic       if_rsp_valid;
  logic [7:0] if_rsp_data;
  logic       dm_req;
  logic       dm_we;
  logic [7:0] dm_addr;
  logic [7:0] dm_wr_data;
  logic       dm_rsp_valid;
  logic [7:0] dm_rsp_data;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wr_data;
  logic       mem_ready;
  logic       mem_rd_valid;
  logic [7:0] mem_rd_data;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_if_req       (if_req),
    .i_if_addr      (if_addr),
    .o_if_rsp_valid (if_rsp_valid),
    .o_if_rsp_data  (if_rsp_data),
    .i_dm_req       (dm_req),
    .i_dm_we        (dm_we),
    .i_dm_addr      (dm_addr),
    .i_dm_wr_data   (dm_wr_data),
    .o_dm_rsp_valid (dm_rsp_valid),
    .o_dm_rsp_data  (dm_rsp_data),
    .o_mem_req      (mem_req),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wr_data  (mem_wr_data),
    .i_mem_ready    (mem_ready),
    .i_mem_rd_valid (mem_rd_valid),
    .i_mem_rd_data  (mem_rd_data)
  );

  typedef struct packed {
    logic       port;  // 0 = fetch, 1 = data
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] mem_model [256];
  int         ready_dly;
  int         rd_dly;
  int         spur_req;
  int         spur_done;
  logic       r_we;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] exp_if_hold;
  logic [7:0] exp_dm_hold;
  logic       exp_last;
  logic [7:0] fq[$];
  logic [7:0] dq[$];
  logic       w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected winner among pending requesters (1 = data).
  function automatic logic pick(input logic f, input logic d);
    if (f && d) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return (exp_last == 1'b1) ? 1'b0 : 1'b1;
`else
      return 1'b1;
`endif
    end
    return d;
  endfunction

  function automatic void push_exp(input logic port, input logic we, input logic [7:0] addr);
    exp_t e;
    e.port = port;
    if (port) begin
      if (!we) exp_dm_hold = mem_model[addr];
      e.data = exp_dm_hold;
    end else begin
      exp_if_hold = mem_model[addr];
      e.data = exp_if_hold;
    end
    exp_last = port;
    sb.push_back(e);
  endfunction

  task automatic if_txn(input logic [7:0] a);
    bit done;
    done = 1'b0;
    if_addr = a;
    if_req = 1'b1;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (if_rsp_valid) done = 1'b1;
    end
    if_req = 1'b0;
    check("if_txn_done", 32'(done), 32'd1);
  endtask

  task automatic dm_txn(input logic we, input logic [7:0] a, input logic [7:0] d);
    bit done;
    done = 1'b0;
    dm_we = we;
    dm_addr = a;
    dm_wr_data = d;
    dm_req = 1'b1;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (dm_rsp_valid) done = 1'b1;
    end
    dm_req = 1'b0;
    check("dm_txn_done", 32'(done), 32'd1);
  endtask

  // Memory responder: ready after ready_dly cycles, read data after rd_dly.
  initial begin
    mem_ready = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data = '0;
    spur_done = 0;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'(i) ^ 8'hA5;
    mem_model[8'h10] = 8'h3A;
    mem_model[8'h90] = 8'hC3;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        r_we = mem_we;
        r_addr = mem_addr;
        r_wdata = mem_wr_data;
        for (int i = 0; i < ready_dly; i++) @(negedge clk);
        mem_ready = 1'b1;
        if (!r_we && rd_dly == 0) begin
          mem_rd_valid = 1'b1;
          mem_rd_data = mem_model[r_addr];
        end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rd_valid = 1'b0;
        if (r_we) begin
          mem_model[r_addr] = r_wdata;
        end else if (rd_dly != 0) begin
          for (int i = 1; i < rd_dly; i++) @(negedge clk);
          mem_rd_valid = 1'b1;
          mem_rd_data = mem_model[r_addr];
          @(negedge clk);
          mem_rd_valid = 1'b0;
        end
      end else if (spur_req != spur_done) begin
        mem_rd_valid = 1'b1;
        mem_rd_data = 8'hFF;
        @(negedge clk);
        mem_rd_valid = 1'b0;
        spur_done++;
      end
    end
  end

  // Response monitor: every pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (if_rsp_valid || dm_rsp_valid)) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'({if_rsp_valid, dm_rsp_valid}), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_port", 32'({if_rsp_valid, dm_rsp_valid}), e.port ? 32'd1 : 32'd2);
          check("rsp_data", 32'(e.port ? dm_rsp_data : if_rsp_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    if_req = 1'b0;
    if_addr = '0;
    dm_req = 1'b0;
    dm_we = 1'b0;
    dm_addr = '0;
    dm_wr_data = '0;
    ready_dly = 0;
    rd_dly = 0;
    spur_req = 0;
    exp_last = 1'b0;
    exp_if_hold = '0;
    exp_dm_hold = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({mem_req, mem_we, mem_addr, mem_wr_data, if_rsp_valid,
                                if_rsp_data, dm_rsp_valid, dm_rsp_data}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fetch with zero-wait memory
    push_exp(1'b0, 1'b0, 8'h10);
    if_addr = 8'h10;
    if_req = 1'b1;
    @(negedge clk);
    check("fetch_issue", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, 1'b0, 8'h10}));
    @(negedge clk);
    check("fetch_rsp", 32'({if_rsp_valid, dm_rsp_valid, if_rsp_data}), 32'({2'b10, 8'h3A}));
    if_req = 1'b0;
    @(negedge clk);
    check("fetch_pulse_end", 32'({if_rsp_valid, dm_rsp_valid}), 32'd0);

    // Data write with ready held off
    ready_dly = 2;
    push_exp(1'b1, 1'b1, 8'h20);
    dm_we = 1'b1;
    dm_addr = 8'h20;
    dm_wr_data = 8'h55;
    dm_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wr_hold", 32'({mem_req, mem_we, mem_addr, mem_wr_data}), 32'({2'b11, 8'h20, 8'h55}));
    end
    @(negedge clk);
    check("wr_rsp", 32'({dm_rsp_valid, if_rsp_valid, mem_req}), 32'b100);
    dm_req = 1'b0;
    dm_we = 1'b0;
    @(negedge clk);
    check("wr_mem", 32'(mem_model[8'h20]), 32'h55);
    check("wr_pulse_end", 32'(dm_rsp_valid), 32'd0);
    ready_dly = 0;

    // Ties: both requesters hold and immediately re-request
    fq = '{8'h01, 8'h02};
    dq = '{8'h80, 8'h81};
    while (fq.size() != 0 || dq.size() != 0) begin
      w = pick(fq.size() != 0, dq.size() != 0);
      if (w) push_exp(1'b1, 1'b0, dq.pop_front());
      else   push_exp(1'b0, 1'b0, fq.pop_front());
    end
    @(negedge clk);
    fork
      begin if_txn(8'h01); if_txn(8'h02); end
      begin dm_txn(1'b0, 8'h80, 8'h00); dm_txn(1'b0, 8'h81, 8'h00); end
    join
    @(negedge clk);

    // Read with late data through RD_WAIT
    rd_dly = 4;
    push_exp(1'b1, 1'b0, 8'h90);
    dm_we = 1'b0;
    dm_addr = 8'h90;
    dm_req = 1'b1;
    @(negedge clk);
    check("rd_issue", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, 1'b0, 8'h90}));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rd_wait", 32'({mem_req, if_rsp_valid, dm_rsp_valid}), 32'd0);
    end
    @(negedge clk);
    check("rd_rsp", 32'({dm_rsp_valid, dm_rsp_data}), 32'({1'b1, 8'hC3}));
    dm_req = 1'b0;
    @(negedge clk);
    check("rd_hold", 32'({dm_rsp_valid, dm_rsp_data}), 32'({1'b0, 8'hC3}));

    // Spurious read data while idle
    rd_dly = 0;
    spur_req++;
    repeat (4) @(negedge clk);
    check("spur_hold", 32'({if_rsp_data, dm_rsp_data}), 32'({exp_if_hold, exp_dm_hold}));
    check("spur_idle", 32'({mem_req, if_rsp_valid, dm_rsp_valid}), 32'd0);

    // Reset during RD_WAIT
    rd_dly = 6;
    dm_we = 1'b0;
    dm_addr = 8'h44;
    dm_req = 1'b1;
    @(negedge clk);
    check("abort_issue", 32'(mem_req), 32'd1);
    @(negedge clk);
    check("abort_rdwait", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    dm_req = 1'b0;
    #1;
    check("abort_reset", 32'({mem_req, if_rsp_valid, dm_rsp_valid, dm_rsp_data, if_rsp_data}), 32'd0);
    exp_if_hold = '0;
    exp_dm_hold = '0;
    exp_last = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_late_ignored", 32'({mem_req, if_rsp_valid, dm_rsp_valid, dm_rsp_data}), 32'd0);
    rd_dly = 0;

    // Normal fetch after reset release
    push_exp(1'b0, 1'b0, 8'h33);
    if_txn(8'h33);
    @(negedge clk);
    check("post_reset_fetch_data", 32'(if_rsp_data), 32'(8'h33 ^ 8'hA5));
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
